// File: rtl/regfile_scoreboard.sv
// Register file: two registered read ports, a write port, a link write port and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read of the same register.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int LINK_REG = 8
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                rd_a_en,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic                rd_a_busy,
  input  logic                rd_b_en,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_b_data,
  output logic                rd_b_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                link_en,
  input  logic [DATA_W-1:0]   link_data,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_err,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     pending_cnt
);

  logic [DATA_W-1:0]   regs_reg  [NUM_REGS];
  logic [DATA_W-1:0]   regs_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg, busy_next, commit_vec, err_vec;
  logic                rsv_err_reg;
  logic [ADDR_W:0]     pending_reg, pending_next;

  logic                rd_en        [2];
  logic [ADDR_W-1:0]   rd_addr      [2];
  logic [DATA_W-1:0]   rd_sel_data  [2];
  logic                rd_sel_busy  [2];
  logic [DATA_W-1:0]   rd_data_reg  [2];
  logic                rd_busy_reg  [2];

  // Register 0 is a constant zero; other entries take link data over wr data.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_next[gi]  = '0;
        assign busy_next[gi]  = 1'b0;
        assign commit_vec[gi] = 1'b0;
        assign err_vec[gi]    = 1'b0;
      end else begin : g_live
        logic wr_hit, link_hit, rsv_hit;
        assign wr_hit         = wr_en && (wr_addr == ADDR_W'(gi));
        assign link_hit       = link_en && (gi == LINK_REG);
        assign rsv_hit        = rsv_en && (rsv_addr == ADDR_W'(gi));
        assign commit_vec[gi] = wr_hit | link_hit;
        assign regs_next[gi]  = link_hit ? link_data : (wr_hit ? wr_data : regs_reg[gi]);
        // A new reservation outranks a completing write in the same cycle.
        assign busy_next[gi]  = rsv_hit | (busy_reg[gi] & ~commit_vec[gi]);
        assign err_vec[gi]    = rsv_hit & busy_reg[gi] & ~commit_vec[gi];
      end
    end
  endgenerate

  assign rd_en[0]   = rd_a_en;
  assign rd_en[1]   = rd_b_en;
  assign rd_addr[0] = rd_a_addr;
  assign rd_addr[1] = rd_b_addr;

  // Out-of-range and zero addresses match no entry and so read as 0, not busy.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_comb begin
        rd_sel_data[gi] = '0;
        rd_sel_busy[gi] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
          if (rd_addr[gi] == ADDR_W'(i)) begin
`ifdef REGFILE_BYPASS_EN
            rd_sel_data[gi] = regs_next[i];
`else
            rd_sel_data[gi] = regs_reg[i];
`endif
            rd_sel_busy[gi] = busy_reg[i];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_next = pending_next + (ADDR_W+1)'(busy_reg[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      for (int p = 0; p < 2; p++) begin
        rd_data_reg[p] <= '0;
        rd_busy_reg[p] <= 1'b0;
      end
      busy_reg    <= '0;
      rsv_err_reg <= 1'b0;
      pending_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= regs_next[i];
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          rd_data_reg[p] <= rd_sel_data[p];
          rd_busy_reg[p] <= rd_sel_busy[p];
        end
      end
      busy_reg    <= busy_next;
      rsv_err_reg <= |err_vec;
      pending_reg <= pending_next;
    end
  end

  assign rd_a_data   = rd_data_reg[0];
  assign rd_a_busy   = rd_busy_reg[0];
  assign rd_b_data   = rd_data_reg[1];
  assign rd_b_busy   = rd_busy_reg[1];
  assign rsv_err     = rsv_err_reg;
  assign busy_vec    = busy_reg;
  assign pending_cnt = pending_reg;

endmodule
